// File: rtl/cpu_pkg.sv
// Shared encodings for the 6502 interrupt sequencer: bus direction, FSM states,
// interrupt sources and the default vector/stack addresses.
package cpu_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [15:0] DEFAULT_VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] DEFAULT_VEC_RST    = 16'hFFFC;
  localparam logic [15:0] DEFAULT_VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  DEFAULT_STACK_PAGE = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_PCH = 3'd1,
    S_PUSH_PCL = 3'd2,
    S_PUSH_P   = 3'd3,
    S_VEC_LO   = 3'd4,
    S_VEC_HI   = 3'd5,
    S_LOAD     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SRC_RST = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } source_t;

  // Stacked P always has bit5 set; bit4 (B) distinguishes BRK from hardware interrupts.
  function automatic logic [7:0] pushed_status(input logic [7:0] p, input logic is_brk);
    return {p[7:6], 1'b1, is_brk, p[3:0]};
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Rising-edge detector for the NMI line; the pending flag holds until the
// sequencer acknowledges it, and the current edge is visible combinationally.
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi,
  input  logic ack,
  output logic pending
);

  logic nmi_q;
  logic pending_q;
  logic rise;

  assign rise    = nmi & ~nmi_q;
  assign pending = pending_q | rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (ack)       pending_q <= 1'b0;
      else if (rise) pending_q <= 1'b1;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer: pushes PCH, PCL and P, fetches the
// vector and hands the new PC to the program counter while stalling the core.
module interrupt_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] VEC_NMI    = DEFAULT_VEC_NMI,
  parameter logic [15:0] VEC_RST    = DEFAULT_VEC_RST,
  parameter logic [15:0] VEC_IRQ    = DEFAULT_VEC_IRQ,
  parameter logic [7:0]  STACK_PAGE = DEFAULT_STACK_PAGE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_boundary,
  input  logic        nmi,
  input  logic        irq,
  input  logic        brk,
  input  logic        i_flag,
  input  logic [15:0] pc,
  input  logic [7:0]  status,
  input  logic [7:0]  sp,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] address,
  output logic [7:0]  data_out,
  output logic        read_write,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_next,
  output logic        set_i
);

  state_t      state_q, state_d;
  source_t     source_q, source_d;
  logic [7:0]  vec_lo_q, vec_hi_q;
  logic [15:0] vector_base;
  logic        nmi_pending;
  logic        nmi_ack;

  nmi_edge_detect u_nmi_edge (
    .clk     (clk),
    .rst     (rst),
    .nmi     (nmi),
    .ack     (nmi_ack),
    .pending (nmi_pending)
  );

  // NOTE: the vector registers are plain control-path flops, so they are reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_VEC_LO;
      source_q <= SRC_RST;
      vec_lo_q <= 8'h00;
      vec_hi_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      source_q <= source_d;
      if (state_q == S_VEC_LO) vec_lo_q <= data_in;
      if (state_q == S_VEC_HI) vec_hi_q <= data_in;
    end
  end

  always_comb begin
    case (source_q)
      SRC_NMI: vector_base = VEC_NMI;
      SRC_RST: vector_base = VEC_RST;
      default: vector_base = VEC_IRQ;
    endcase
  end

  assign pc_next = {vec_hi_q, vec_lo_q};

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    source_d   = source_q;
    busy       = 1'b1;
    address    = 16'h0000;
    data_out   = 8'h00;
    read_write = READ;
    sp_dec     = 1'b0;
    pc_load    = 1'b0;
    set_i      = 1'b0;
    nmi_ack    = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (instr_boundary) begin
          if (nmi_pending) begin
            source_d = SRC_NMI;
            nmi_ack  = 1'b1;
            state_d  = S_PUSH_PCH;
          end else if (brk) begin
            source_d = SRC_BRK;
            state_d  = S_PUSH_PCH;
          end else if (irq && !i_flag) begin
            source_d = SRC_IRQ;
            state_d  = S_PUSH_PCH;
          end
        end
      end
      S_PUSH_PCH: begin
        address    = {STACK_PAGE, sp};
        data_out   = pc[15:8];
        read_write = WRITE;
        sp_dec     = 1'b1;
        state_d    = S_PUSH_PCL;
      end
      S_PUSH_PCL: begin
        address    = {STACK_PAGE, sp};
        data_out   = pc[7:0];
        read_write = WRITE;
        sp_dec     = 1'b1;
        state_d    = S_PUSH_P;
      end
      S_PUSH_P: begin
        address    = {STACK_PAGE, sp};
        data_out   = pushed_status(status, source_q == SRC_BRK);
        read_write = WRITE;
        sp_dec     = 1'b1;
        state_d    = S_VEC_LO;
      end
      S_VEC_LO: begin
        address = vector_base;
        state_d = S_VEC_HI;
      end
      S_VEC_HI: begin
        address = vector_base + 16'd1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        pc_load = 1'b1;
        set_i   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Sequences the 6502 interrupt, BRK and reset entry micro-operations on the shared memory bus.
It runs only at instruction boundaries, while the control unit sits in FETCH. It pushes PCH, PCL and P onto the stack page, reads the selected vector, and hands a new PC to the program counter.
While `busy` is high, the control unit is stalled and this block owns address, data_out and read_write.

Parameters:
VEC_NMI, 16'hFFFA, NMI vector low-byte address
VEC_RST, 16'hFFFC, reset vector low-byte address
VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address
STACK_PAGE, 8'h01, high byte of every stack address

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
instr_boundary  in  1  control unit is in FETCH and may accept a new instruction
nmi  in  1  NMI request, level input, rising-edge sensitive
irq  in  1  IRQ request, level sensitive
brk  in  1  BRK opcode decoded, valid with instr_boundary
i_flag  in  1  status I bit
pc  in  16  current PC (return address to push)
status  in  8  current P register
sp  in  8  current stack pointer
data_in  in  8  memory read data
busy  out  1  sequencer owns the bus; stall control unit
address  out  16  bus address while busy
data_out  out  8  bus write data
read_write  out  1  0 = read, 1 = write
sp_dec  out  1  decrement SP at end of this cycle
pc_load  out  1  load pc_next into PC
pc_next  out  16  vector target
set_i  out  1  set I flag (same cycle as pc_load)

Behaviour:
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD.
- Reset (async, rst=1):
  - state=VEC_LO, source=RST, nmi_pending=0, vector regs=0.
  - Outputs: busy=1, address=VEC_RST, read_write=0, data_out=0, sp_dec=0, pc_load=0, set_i=0.
- Reset sequence: VEC_LO -> VEC_HI -> LOAD -> IDLE. No stack writes and no sp_dec.
- NMI edge detect: nmi_pending is set on a 0->1 transition of registered nmi. It is cleared on the cycle the FSM leaves IDLE with source NMI.
- IDLE: busy=0, address=0, read_write=0, all strobes 0.
- IDLE with instr_boundary=1: source is chosen by priority nmi_pending > brk > (irq & ~i_flag). If any source is selected, the FSM moves to PUSH_PCH next cycle; otherwise it stays in IDLE.
- PUSH_PCH: address={STACK_PAGE,sp}, data_out=pc[15:8], read_write=1, sp_dec=1.
- PUSH_PCL: same addressing (SP already decremented), data_out=pc[7:0], read_write=1, sp_dec=1.
- PUSH_P: data_out=status with bit5=1 and bit4=1 if source=BRK, else bit4=0; read_write=1, sp_dec=1.
- VEC_LO: address = vector for the source (BRK uses VEC_IRQ); read_write=0; vec_lo<=data_in at clock edge.
- VEC_HI: address=vector+1; vec_hi<=data_in.
- LOAD: pc_load=1, set_i=1, pc_next={vec_hi,vec_lo}, busy=1. Next state is IDLE.
- Latency: interrupt entry = 6 busy cycles after the request is sampled (PUSH x3, VEC x2, LOAD). Reset entry = 3 busy cycles.
- pc and status must stay stable while busy; this block does not latch them.
- irq deasserting mid-sequence: the sequence completes unchanged.
- NMI edge arriving while busy: latched, and serviced at the first boundary after returning to IDLE.
- nmi and irq in the same cycle: NMI is taken. IRQ is masked afterwards by set_i.
- brk together with a pending NMI: NMI is taken and brk is dropped. The control unit re-fetches the instruction.
- rst asserted mid-sequence: abort immediately. Already-written stack bytes are not undone.
- SP wraps 8'h00 -> 8'hFF. The SP register is owned externally; this block only pulses sp_dec.

Decomposition:
- cpu_pkg holds:
  - the read/write constants (read=0, write=1);
  - the state encoding (3-bit, IDLE=0);
  - the source encoding (RST, NMI, IRQ, BRK);
  - the default vector addresses.
- One natural sub-module: nmi_edge_detect (register nmi, set pending on rising edge, clear on acknowledge strobe, async reset).

Test Plan:
- Release rst with mem[FFFC]=34, mem[FFFD]=12 -> busy=1 for 3 cycles, reads FFFC then FFFD, then pc_load=1 with pc_next=16'h1234 and set_i=1, then busy=0.
- IDLE, pc=16'hC005, sp=8'hFD, status=8'h00, irq=1, i_flag=0, instr_boundary=1, mem[FFFE/F]=00/80 -> writes 01FD=C0, 01FC=05, 01FB=20; 3 sp_dec pulses; pc_next=16'h8000.
- brk=1 at boundary, status=8'h01 -> pushed P=8'h31, vector read from FFFE.
- nmi rising edge and irq=1 in the same cycle at boundary -> vector FFFA used, pushed P bit4=0; irq not re-serviced after LOAD (set_i asserted).
- irq=1 with i_flag=1 at boundary -> stays IDLE, busy=0. nmi pulsed during an IRQ sequence -> second sequence via FFFA starts 1 cycle after the next boundary following LOAD.
- rst asserted during PUSH_PCL -> next cycle outputs address=FFFC, read_write=0, busy=1; nmi_pending cleared.
